seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with per-frame input shadowing,
// blink, decimal points and leading-zero blanking. Outputs are active-low.
module seg_scan_driver #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digits,
   input  logic [7:0]  en_mask,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blink_mask,
   input  logic        lzb,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        frame_start
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic             tick;
   logic             boundary;

   logic [BLK_W-1:0] blink_cnt;
   logic             blink_phase;

   logic [31:0]      sh_digits;
   logic [7:0]       sh_en;
   logic [7:0]       sh_dp;
   logic [7:0]       sh_blink;
   logic             sh_lzb;

   logic [3:0]       cur_code;
   logic             upper_zero;
   logic             blank;
   logic [7:0]       an_nxt;
   logic [7:0]       seg_nxt;

   assign tick     = (div_cnt == DIV_LAST);
   assign boundary = tick && (idx == 3'd7);

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Slot divider and slot index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= 3'd0;
      end else if (tick) begin
         div_cnt <= '0;
         idx     <= idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Blink phase flips once every BLINK_FRAMES frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (boundary) begin
         if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   // Inputs are only sampled at frame boundaries so a frame is always coherent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_digits <= 32'h0;
         sh_en     <= 8'h00;
         sh_dp     <= 8'h00;
         sh_blink  <= 8'h00;
         sh_lzb    <= 1'b0;
      end else if (boundary) begin
         sh_digits <= digits;
         sh_en     <= en_mask;
         sh_dp     <= dp_mask;
         sh_blink  <= blink_mask;
         sh_lzb    <= lzb;
      end
   end

   always_comb begin
      cur_code   = sh_digits[{idx, 2'b00} +: 4];
      upper_zero = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if ((3'(i) >= idx) && (sh_digits[4*i +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
         end
      end
      blank = !sh_en[idx]
              || (blink_phase && sh_blink[idx])
              || (sh_lzb && (idx != 3'd0) && upper_zero);
      an_nxt  = 8'hFF;
      seg_nxt = 8'hFF;
      if (!blank) begin
         an_nxt  = ~(8'h01 << idx);
         seg_nxt = {~sh_dp[idx], decode(cur_code)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an          <= 8'hFF;
         seg         <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         an          <= an_nxt;
         seg         <= seg_nxt;
         frame_start <= boundary;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random input changes,
// checked every cycle against an arithmetic model of the scan timeline.
module tb_seg_scan_driver;

   localparam int D  = 4;
   localparam int BF = 2;
   localparam int FRAME = 8 * D;

   logic        clk;
   logic        rst;
   logic [31:0] digits;
   logic [7:0]  en_mask;
   logic [7:0]  dp_mask;
   logic [7:0]  blink_mask;
   logic        lzb;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frame_start;

   int errors = 0;
   int checks = 0;

   // model: edges since reset release, boundaries seen, shadow copies
   int          k;
   int          nb;
   logic [31:0] m_dig;
   logic [7:0]  m_en, m_dp, m_bl;
   logic        m_lzb;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_driver #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
      .clk         (clk),
      .rst         (rst),
      .digits      (digits),
      .en_mask     (en_mask),
      .dp_mask     (dp_mask),
      .blink_mask  (blink_mask),
      .lzb         (lzb),
      .an          (an),
      .seg         (seg),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at k=%0d: observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0; nb = 0;
      m_dig = 32'h0; m_en = 8'h0; m_dp = 8'h0; m_bl = 8'h0; m_lzb = 1'b0;
   endtask

   task automatic step();
      logic [7:0] e_an, e_seg;
      logic       e_fs, ph, allz, blank;
      int         pi;
      @(posedge clk);
      k++;
      pi    = ((k - 1) / D) % 8;
      ph    = ((nb / BF) % 2) == 1;
      allz  = (m_dig >> (4 * pi)) == 32'h0;
      blank = !m_en[pi] || (ph && m_bl[pi]) || (m_lzb && pi >= 1 && allz);
      e_an  = blank ? 8'hFF : ~(8'h01 << pi);
      e_seg = blank ? 8'hFF : {~m_dp[pi], dec[m_dig[4*pi +: 4]]};
      e_fs  = (k % FRAME) == 0;
      if (e_fs) begin
         nb++;
         m_dig = digits; m_en = en_mask; m_dp = dp_mask; m_bl = blink_mask; m_lzb = lzb;
      end
      @(negedge clk);
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("frame_start", frame_start, e_fs);
      chk("an_onehot", ($countones(~an) <= 1), 1);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic run_to_idx(input int target);
      int guard = 0;
      while (((k / D) % 8) != target && guard < 2 * FRAME) begin
         step();
         guard++;
      end
      chk("run_to_idx_bound", (guard < 2 * FRAME), 1);
   endtask

   initial begin
      int first_fs;
      rst = 1'b1;
      digits = 32'h76543210; en_mask = 8'hFF; dp_mask = 8'h00;
      blink_mask = 8'h00; lzb = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_fs", frame_start, 1'b0);
      rst = 1'b0;

      // basic scan, first capture after one full frame
      run(31);
      chk("pre_boundary_an", an, 8'hFF);
      run(1);
      chk("first_fs", frame_start, 1'b1);
      step();
      chk("slot0_an", an, 8'hFE);
      chk("slot0_seg", seg, 8'hC0);
      run(4);
      chk("slot1_an", an, 8'hFD);
      chk("slot1_seg", seg, 8'hF9);
      run(FRAME);

      // leading-zero blanking, then a mid-frame change that must wait a frame
      digits = 32'h00000305; lzb = 1'b1; dp_mask = 8'h00;
      run(2 * FRAME);
      run_to_idx(3);
      digits = 32'h00009999;
      run(2 * FRAME);

      // blink with decimal point on digit 0
      digits = 32'h0; lzb = 1'b0; blink_mask = 8'h01; dp_mask = 8'h01; en_mask = 8'h01;
      run(9 * FRAME);

      // random input changes at arbitrary cycles
      for (int c = 0; c < 8 * FRAME; c++) begin
         if ($urandom_range(15) == 0) begin
            digits     = $urandom;
            en_mask    = 8'($urandom);
            dp_mask    = 8'($urandom);
            blink_mask = 8'($urandom);
            lzb        = 1'($urandom);
         end
         step();
      end

      // reset mid-frame at slot 5
      digits = 32'h12345678; en_mask = 8'hFF; blink_mask = 8'h00; lzb = 1'b0;
      run_to_idx(5);
      rst = 1'b1;
      #1;
      chk("midrst_an", an, 8'hFF);
      chk("midrst_seg", seg, 8'hFF);
      chk("midrst_fs", frame_start, 1'b0);
      @(negedge clk);
      chk("midrst_hold_an", an, 8'hFF);
      rst = 1'b0;
      model_reset();
      first_fs = 0;
      for (int c = 0; c < FRAME + 8 && first_fs == 0; c++) begin
         step();
         if (frame_start === 1'b1) first_fs = k;
      end
      chk("fs_after_rst_latency", first_fs, FRAME);
      run(2 * FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
